// File: rtl/seq101_frame_tx.sv
// Serial frame transmitter: header "101", zero-stuffed MSB-first payload, "00" trailer.
// State | meaning: IDLE waiting for a word | HDR sending 1,0,1 | DATA payload and stuff zeros | TRAIL sending 0,0
module seq101_frame_tx #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_bit_o,
    output logic         out_active_o,
    output logic         out_hdr_end_o,
    output logic         out_stuffed_o
);
    localparam int BW = $clog2(W + 1);
    localparam int SW = $clog2(W);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        HDR   = 4'b0010,
        DATA  = 4'b0100,
        TRAIL = 4'b1000
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [BW-1:0]  bits_q, bits_d;
    logic [SW-1:0]  stuff_q, stuff_d;
    logic [1:0]     ph_q, ph_d;
    logic [1:0]     hist_q, hist_d;
    logic           out_bit_q, out_bit_d;
    logic           out_active_q, out_active_d;
    logic           out_hdr_end_q, out_hdr_end_d;
    logic           out_stuffed_q, out_stuffed_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bits_q        <= '0;
            stuff_q       <= '0;
            ph_q          <= '0;
            hist_q        <= '0;
            out_bit_q     <= 1'b0;
            out_active_q  <= 1'b0;
            out_hdr_end_q <= 1'b0;
            out_stuffed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bits_q        <= bits_d;
            stuff_q       <= stuff_d;
            ph_q          <= ph_d;
            hist_q        <= hist_d;
            out_bit_q     <= out_bit_d;
            out_active_q  <= out_active_d;
            out_hdr_end_q <= out_hdr_end_d;
            out_stuffed_q <= out_stuffed_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bits_d        = bits_q;
        stuff_d       = stuff_q;
        ph_d          = ph_q;
        hist_d        = hist_q;
        out_bit_d     = 1'b0;
        out_active_d  = 1'b0;
        out_hdr_end_d = 1'b0;
        out_stuffed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    shift_d = in_data_i;
                    bits_d  = '0;
                    stuff_d = '0;
                    ph_d    = '0;
                    hist_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                out_active_d = 1'b1;
                out_bit_d    = (ph_q != 2'd1);
                ph_d         = ph_q + 2'd1;
                if (ph_q == 2'd2) begin
                    out_hdr_end_d = 1'b1;
                    hist_d        = 2'b01;
                    bits_d        = BW'(W);
                    ph_d          = '0;
                    state_d       = DATA;
                end
            end
            DATA: begin
                out_active_d = 1'b1;
                // A "10" history followed by a 1 would forge a header; break it with a zero.
                if (hist_q == 2'b10) begin
                    out_stuffed_d = 1'b1;
                    hist_d        = {hist_q[0], 1'b0};
                    stuff_d       = stuff_q + SW'(1);
                end else begin
                    out_bit_d = shift_q[W-1];
                    shift_d   = {shift_q[W-2:0], 1'b0};
                    hist_d    = {hist_q[0], shift_q[W-1]};
                    bits_d    = bits_q - BW'(1);
                    if (bits_q == BW'(1)) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (ph_q == 2'd2) begin
                    ph_d    = '0;
                    state_d = IDLE;
                end else begin
                    out_active_d = 1'b1;
                    ph_d         = ph_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o    = (state_q == IDLE);
    assign out_bit_o     = out_bit_q;
    assign out_active_o  = out_active_q;
    assign out_hdr_end_o = out_hdr_end_q;
    assign out_stuffed_o = out_stuffed_q;
endmodule
